// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: one load/store in flight, lane steering, misalign reject.
// Optional access watchdog enabled by defining DM_ACCESS_CTRL_TIMEOUT_EN.
module dm_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_LW = 6'd16, OP_SW = 6'd17, OP_LH = 6'd18;
  localparam logic [5:0] OP_SH = 6'd19, OP_LB = 6'd20, OP_SB = 6'd21;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  op_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic        is_mem, misal, accept, busy, op_load, complete, capture, timeout;

  function automatic logic [3:0] byte_en(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_SW:   byte_en = 4'b1111;
      OP_SH:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      OP_SB:   byte_en = 4'b0001 << off;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] wd);
    case (op)
      OP_SH:   store_lanes = {2{wd[15:0]}};
      OP_SB:   store_lanes = {4{wd[7:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_lanes(input logic [5:0] op, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (op)
      OP_LH:   load_lanes = {16'h0000, sh[15:0]};
      OP_LB:   load_lanes = {24'h000000, sh[7:0]};
      default: load_lanes = rd;
    endcase
  endfunction

  assign is_mem  = ex_op inside {OP_LW, OP_SW, OP_LH, OP_SH, OP_LB, OP_SB};
  assign misal   = ((ex_op == OP_LW || ex_op == OP_SW) && ex_addr[1:0] != 2'b00) ||
                   ((ex_op == OP_LH || ex_op == OP_SH) && ex_addr[0]);
  // Gated by rst so the combinational outputs are also quiet while reset is held.
  assign accept  = ~rst & (state == IDLE) & ex_valid & is_mem & ~misal;
  assign busy    = (state == REQ) || (state == WAIT);
  assign op_load = op_q inside {OP_LW, OP_LH, OP_LB};

  assign complete = ((state == REQ) && mem_gnt && (!op_load || mem_rvalid)) ||
                    ((state == WAIT) && mem_rvalid);
  assign capture  = complete && op_load;

`ifdef DM_ACCESS_CTRL_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  logic          err_q;

  assign timeout = busy && (cnt == CW'(TIMEOUT_CYC - 1));
  assign err     = (state == DONE) & err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (timeout && !complete) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ: begin
        if (complete || timeout) state_nxt = DONE;
        else if (mem_gnt)        state_nxt = WAIT;
      end
      WAIT: if (complete || timeout) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields latch on accept; the result register is zeroed so stores and aborts return 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else if (accept) begin
      op_q    <= ex_op;
      addr_q  <= ex_addr;
      wdata_q <= ex_wdata;
      data_q  <= '0;
    end else if (capture) begin
      data_q  <= load_lanes(op_q, addr_q[1:0], mem_rdata);
    end
  end

  assign stall     = busy | accept;
  assign misalign  = ~rst & (state == IDLE) & ex_valid & is_mem & misal;
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & ~op_load;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? byte_en(op_q, addr_q[1:0]) : 4'h0;
  assign mem_wdata = mem_we ? store_lanes(op_q, wdata_q) : 32'h0;
  assign wb_valid  = (state == DONE);
  assign wb_data   = wb_valid ? data_q : 32'h0;

endmodule
